// File: rtl/lms_seq.sv
// Control sequencer for a bit-serial distributed-arithmetic LMS filter: IDLE -> LOAD -> ACC x NBITS -> OUT -> HOLD.
// Optional convergence monitor enabled by defining LMS_SEQ_CONV_MON_EN (adds the converged output).
module lms_seq #(
  parameter int NBITS = 8,
  parameter int TW    = 3,
  parameter int EW    = 10
) (
  input  logic          clk,
  input  logic          r,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lat_x,
  output logic          lat_d,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [TW-1:0] t,
  output logic          oe_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          upd_en,
  input  logic          freeze,
  input  logic [EW-1:0] e_in,
`ifdef LMS_SEQ_CONV_MON_EN
  output logic          converged,
`endif
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ACC, OUT, HOLD} state_t;

  localparam logic [TW-1:0] T_LAST = TW'(NBITS - 1);

  state_t state;
  logic   hold_exit;
  logic   upd_block;

  assign hold_exit = (state == HOLD) && out_ready;

  // Strobes are registered alongside the state so each is a clean flop output.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      t         <= '0;
      in_ready  <= 1'b1;
      lat_x     <= 1'b0;
      lat_d     <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      oe_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      lat_x   <= 1'b0;
      lat_d   <= 1'b0;
      acc_clr <= 1'b0;
      oe_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= LOAD;
            in_ready <= 1'b0;
            lat_x    <= 1'b1;
            lat_d    <= 1'b1;
            acc_clr  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state  <= ACC;
          acc_en <= 1'b1;
          t      <= '0;
        end
        ACC: begin
          if (t == T_LAST) begin
            state  <= OUT;
            acc_en <= 1'b0;
            t      <= '0;
            oe_en  <= 1'b1;
          end else begin
            t <= t + TW'(1);
          end
        end
        OUT: begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          t         <= '0;
          in_ready  <= 1'b1;
          acc_en    <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The update strobe must coincide with the consuming handshake, so it is decoded from the live out_ready.
  assign upd_en = hold_exit && !freeze && !upd_block;

`ifdef LMS_SEQ_CONV_MON_EN
  logic [3:0]  conv_cnt;
  logic [EW:0] e_mag;
  logic        e_small;

  always_comb begin
    e_mag   = e_in[EW-1] ? ({1'b0, ~e_in} + (EW+1)'(1)) : {1'b0, e_in};
    e_small = e_mag < (EW+1)'(2 ** (EW - 4));
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      conv_cnt <= 4'd0;
    end else if (hold_exit) begin
      if (!e_small)
        conv_cnt <= 4'd0;
      else if (conv_cnt != 4'd15)
        conv_cnt <= conv_cnt + 4'd1;
    end
  end

  assign converged = (conv_cnt == 4'd15);
  assign upd_block = converged;
`else
  logic unused_e_in;
  assign unused_e_in = ^e_in;
  assign upd_block   = 1'b0;
`endif

endmodule

// File: tb/tb_lms_seq.sv
// Directed bench for lms_seq: per-cycle strobe timing, HOLD stretch, freeze, mid-sample reset, back-to-back samples.
module tb_lms_seq;
  localparam int NBITS = 8;
  localparam int TW    = 3;
  localparam int EW    = 10;

  logic          clk = 1'b0;
  logic          r = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          freeze = 1'b0;
  logic [EW-1:0] e_in = '0;
  logic          in_ready, lat_x, lat_d, acc_clr, acc_en, oe_en, out_valid, upd_en, busy;
  logic [TW-1:0] t;
`ifdef LMS_SEQ_CONV_MON_EN
  logic          converged;
`endif

  int n_vec = 0;
  int n_err = 0;

  lms_seq #(.NBITS(NBITS), .TW(TW), .EW(EW)) dut (
    .clk(clk), .r(r), .in_valid(in_valid), .in_ready(in_ready),
    .lat_x(lat_x), .lat_d(lat_d), .acc_clr(acc_clr), .acc_en(acc_en), .t(t),
    .oe_en(oe_en), .out_valid(out_valid), .out_ready(out_ready), .upd_en(upd_en),
    .freeze(freeze), .e_in(e_in),
`ifdef LMS_SEQ_CONV_MON_EN
    .converged(converged),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] pack(input logic ir, input logic lx, input logic ld, input logic ac,
                                       input logic ae, input logic oe, input logic ov, input logic ue,
                                       input logic bz, input logic [TW-1:0] tt);
    return {20'd0, ir, lx, ld, ac, ae, oe, ov, ue, bz, tt};
  endfunction

  function automatic logic [31:0] obs();
    return pack(in_ready, lat_x, lat_d, acc_clr, acc_en, oe_en, out_valid, upd_en, busy, t);
  endfunction

  function automatic logic [31:0] idle_vec();
    return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  // Caller is between edges with the DUT in IDLE. w = extra HOLD cycles with out_ready low.
  task automatic run_sample(input string tag, input int w, input logic frz, input logic exp_upd);
    int ups;
    int last;
    logic ae;
    ups  = 0;
    last = 11 + w;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    freeze    = ~frz;
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk);
      #1;
      in_valid  = (k < last);
      out_ready = (k == last);
      freeze    = (k == last) ? frz : ~frz;
      @(negedge clk);
      if (k == last + 1) begin
        check($sformatf("%s c%0d", tag, k), obs(), idle_vec());
      end else begin
        ae = (k >= 2) && (k <= 9);
        check($sformatf("%s c%0d", tag, k), obs(),
              pack(1'b0, k == 1, k == 1, k == 1, ae, k == 10, k >= 11,
                   (k == last) && exp_upd, 1'b1, ae ? TW'(k - 2) : TW'(0)));
      end
      ups += int'(upd_en);
    end
    freeze = 1'b0;
    check($sformatf("%s upd_count", tag), 32'(ups), exp_upd ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ups;
    int bad_gap;
    int last_up;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs(), idle_vec());
`ifdef LMS_SEQ_CONV_MON_EN
    check("reset_converged", 32'(converged), 32'd0);
`endif
    r = 1'b1;

    run_sample("basic", 0, 1'b0, 1'b1);
    run_sample("hold5", 5, 1'b0, 1'b1);
    run_sample("freeze", 0, 1'b1, 1'b0);
    run_sample("freeze_hold", 3, 1'b1, 1'b0);

    // Abandon a sample with an asynchronous reset while t=4 in ACC.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    ups = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      ups += int'(upd_en);
    end
    check("midreset t_before", 32'(t), 32'd4);
    #2 r = 1'b0;
    #1 check("midreset async", obs(), idle_vec());
    @(posedge clk);
    #1 check("midreset held", obs(), idle_vec());
    r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ups += int'(upd_en);
    end
    check("midreset no_upd", 32'(ups), 32'd0);
    check("midreset idle", obs(), idle_vec());
    run_sample("after_reset", 0, 1'b0, 1'b1);

    // Back-to-back samples: one update every 12 cycles, first at cycle 11.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    ups     = 0;
    bad_gap = 0;
    last_up = -1;
    for (int c = 1; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (c == 599) in_valid = 1'b0;
      @(negedge clk);
      if (upd_en) begin
        ups++;
        if (c - last_up != 12) bad_gap++;
        last_up = c;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("stream upd_count", 32'(ups), 32'd50);
    check("stream bad_gaps", 32'(bad_gap), 32'd0);
    check("stream idle_end", obs(), idle_vec());
    out_ready = 1'b0;

`ifdef LMS_SEQ_CONV_MON_EN
    e_in = EW'(3);
    for (int i = 1; i <= 16; i++) begin
      run_sample($sformatf("conv%0d", i), 0, 1'b0, i < 16);
      check($sformatf("conv%0d converged", i), 32'(converged), (i >= 15) ? 32'd1 : 32'd0);
    end
    e_in = EW'(200);
    run_sample("conv_big", 0, 1'b0, 1'b0);
    check("conv_big converged", 32'(converged), 32'd0);
    run_sample("conv_after", 0, 1'b0, 1'b1);
    check("conv_after converged", 32'(converged), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
